// File: rtl/line_buf_pkg.sv
// Shared types and constants for the 3x3 line-buffer controller.
package line_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int KERNEL = 3;

endpackage

// File: rtl/line_buf_ctrl_rc_counter.sv
// Row/column position of the pixel about to be accepted, with a last-pixel flag.
// Latency: position updates on the edge of each inc; last is combinational from the count.
// Backpressure: none; advances only when inc is high.
module rc_counter #(
    parameter int DIM_BIT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    input  logic [DIM_BIT-1:0] col_max,
    input  logic [DIM_BIT-1:0] row_max,
    output logic [DIM_BIT-1:0] row,
    output logic [DIM_BIT-1:0] col,
    output logic               last
);

    assign last = (row == row_max) && (col == col_max);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (last) begin
                row <= '0;
                col <= '0;
            end else if (col == col_max) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/line_buf_ctrl.sv
// Controls an external FIFO as a two-line delay and flags when 3x3 window taps are valid.
// Latency: FIFO strobes same cycle as accept; win_valid/done one cycle after the accept.
// Backpressure: s_ready only in FILL/STREAM; s_valid low stalls everything.
module line_buf_ctrl
    import line_buf_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int ADDR_BIT = 4,
    parameter int DIM_BIT  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DIM_BIT-1:0]  img_w,
    input  logic [DIM_BIT-1:0]  img_h,
    input  logic                s_valid,
    input  logic [WIDTH-1:0]    s_data,
    output logic                s_ready,
    output logic                fifo_clr,
    output logic                fifo_wen,
    output logic                fifo_ren,
    output logic [WIDTH-1:0]    fifo_in,
    output logic [ADDR_BIT:0]   fifo_depth,
    input  logic [ADDR_BIT:0]   fifo_count,
    input  logic                fifo_empty,
    input  logic                fifo_full,
    output logic                win_valid,
    output logic [DIM_BIT-1:0]  win_row,
    output logic [DIM_BIT-1:0]  win_col,
    output logic                busy,
    output logic                done,
    output logic                cfg_err
);

    state_t               state;
    logic [DIM_BIT-1:0]   w_q;
    logic [DIM_BIT-1:0]   h_q;
    logic [ADDR_BIT:0]    depth_q;
    logic [DIM_BIT-1:0]   row;
    logic [DIM_BIT-1:0]   col;
    logic                 last_pix;
    logic                 cfg_ok;
    logic                 start_ok;
    logic                 accept;
    logic                 in_window;
    logic                 unused_flags;

    // Two full rows must fit in the FIFO for the window's top tap to exist.
    assign cfg_ok    = (img_w >= DIM_BIT'(KERNEL)) && (img_h >= DIM_BIT'(KERNEL)) &&
                       (32'({img_w, 1'b0}) <= (32'(1) << ADDR_BIT));
    assign start_ok  = start && (state == ST_IDLE) && cfg_ok;

    assign s_ready   = !rst && ((state == ST_FILL) || (state == ST_STREAM));
    assign accept    = s_valid && s_ready;
    assign fifo_wen  = accept;
    assign fifo_in   = s_data;
    assign fifo_ren  = accept && (state == ST_STREAM);
    // Combinational so the FIFO is already empty on the first FILL cycle.
    assign fifo_clr  = rst || start_ok;
    assign fifo_depth = depth_q;

    assign in_window = (row >= DIM_BIT'(KERNEL - 1)) && (col >= DIM_BIT'(KERNEL - 1));
    assign unused_flags = fifo_empty ^ fifo_full;

    rc_counter #(.DIM_BIT(DIM_BIT)) u_rc (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_ok),
        .inc     (accept),
        .col_max (w_q - 1'b1),
        .row_max (h_q - 1'b1),
        .row     (row),
        .col     (col),
        .last    (last_pix)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            w_q       <= '0;
            h_q       <= '0;
            depth_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else begin
            done      <= 1'b0;
            win_valid <= accept && in_window;
            win_row   <= (accept && in_window) ? row : '0;
            win_col   <= (accept && in_window) ? col : '0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            w_q     <= img_w;
                            h_q     <= img_h;
                            depth_q <= (ADDR_BIT+1)'({img_w, 1'b0});
                            cfg_err <= 1'b0;
                            busy    <= 1'b1;
                            state   <= ST_FILL;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (accept && (fifo_count == depth_q - 1'b1))
                        state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (accept && last_pix) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Bench for line_buf_ctrl: config table plus scoreboarded frame runs with an occupancy model of the FIFO.
module tb_line_buf_ctrl;

    localparam int WIDTH    = 8;
    localparam int ADDR_BIT = 4;
    localparam int DIM_BIT  = 8;
    localparam int LIMIT    = 400;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [DIM_BIT-1:0]  img_w;
    logic [DIM_BIT-1:0]  img_h;
    logic                s_valid;
    logic [WIDTH-1:0]    s_data;
    logic                s_ready;
    logic                fifo_clr;
    logic                fifo_wen;
    logic                fifo_ren;
    logic [WIDTH-1:0]    fifo_in;
    logic [ADDR_BIT:0]   fifo_depth;
    logic [ADDR_BIT:0]   fifo_count;
    logic                fifo_empty;
    logic                fifo_full;
    logic                win_valid;
    logic [DIM_BIT-1:0]  win_row;
    logic [DIM_BIT-1:0]  win_col;
    logic                busy;
    logic                done;
    logic                cfg_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    line_buf_ctrl #(.WIDTH(WIDTH), .ADDR_BIT(ADDR_BIT), .DIM_BIT(DIM_BIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .img_w      (img_w),
        .img_h      (img_h),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .fifo_clr   (fifo_clr),
        .fifo_wen   (fifo_wen),
        .fifo_ren   (fifo_ren),
        .fifo_in    (fifo_in),
        .fifo_depth (fifo_depth),
        .fifo_count (fifo_count),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .win_valid  (win_valid),
        .win_row    (win_row),
        .win_col    (win_col),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    // Occupancy model of the external FIFO.
    always_ff @(posedge clk) begin
        if (fifo_clr)
            fifo_count <= '0;
        else
            fifo_count <= fifo_count + {4'b0, fifo_wen} - {4'b0, fifo_ren};
    end
    assign fifo_empty = (fifo_count == 0);
    assign fifo_full  = (fifo_count == 5'd16);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1; img_w = 8'd8; img_h = 8'd4;
        @(negedge clk);
        check("clr_during_rst", fifo_clr, 1);
        check("ready_during_rst", s_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("busy_after_rst", busy, 0);
    endtask

    typedef struct {
        int w;
        int h;
        bit err;
        bit bsy;
        int depth;
    } cfg_vec_t;

    typedef struct {
        int r;
        int c;
        int cyc;
    } win_t;

    task automatic run_frame(input int w, input int h, input bit gaps,
                             input int abort_at, input int start_at);
        win_t wq[$];
        win_t e;
        int pix = 0, cyc = 0, last_acc = -1, done_cyc = -1;
        int fill_w = 0, first_ren = 0, wins = 0;
        int wen_err = 0, ren_err = 0, dat_err = 0, idle_err = 0;
        bit acc, fin = 0, aborted = 0;
        @(posedge clk); #1;
        start = 1'b1; img_w = DIM_BIT'(w); img_h = DIM_BIT'(h);
        @(negedge clk);
        check("clr_on_start", fifo_clr, 1);
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < LIMIT && !fin && !aborted) begin
            @(posedge clk); #1;
            s_valid = gaps ? (cyc % 2 == 0) : 1'b1;
            s_data  = WIDTH'(pix + 1);
            start   = (start_at != 0 && pix == start_at);
            img_w   = start ? 8'd3 : DIM_BIT'(w);
            @(negedge clk);
            if (win_valid) begin
                wins++;
                if (wq.size() == 0) check("win_unexpected", 1, 0);
                else begin
                    e = wq.pop_front();
                    check("win_row", win_row, e.r);
                    check("win_col", win_col, e.c);
                    check("win_cycle", cyc, e.cyc);
                end
            end
            if (done) begin
                done_cyc = cyc;
                fin = 1;
            end
            acc = s_valid && s_ready;
            if (fifo_wen !== acc) wen_err++;
            if (fifo_ren !== (acc && pix >= 2 * w)) ren_err++;
            if (!s_valid && (fifo_wen || fifo_ren)) idle_err++;
            if (acc) begin
                if (fifo_in !== WIDTH'(pix + 1)) dat_err++;
                if (!fifo_ren) fill_w++;
                else if (first_ren == 0) first_ren = pix + 1;
                if (pix / w >= 2 && pix % w >= 2)
                    wq.push_back('{r: pix / w, c: pix % w, cyc: cyc + 1});
                pix++;
                last_acc = cyc;
            end
            if (abort_at != 0 && pix == abort_at) aborted = 1;
            cyc++;
        end
        start = 1'b0;
        check("wen_pattern_errs", wen_err, 0);
        check("ren_pattern_errs", ren_err, 0);
        check("data_errs", dat_err, 0);
        check("idle_strobe_errs", idle_err, 0);
        if (aborted) begin
            @(posedge clk); #1;
            rst = 1'b1;
            @(negedge clk);
            check("abort_clr", fifo_clr, 1);
            check("abort_no_wen", fifo_wen, 0);
            check("abort_no_done", done, 0);
            @(posedge clk); #1;
            rst = 1'b0; s_valid = 1'b0;
            @(negedge clk);
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            check("abort_win", win_valid, 0);
            check("abort_depth", fifo_depth, 0);
            check("abort_ready", s_ready, 0);
            check("abort_cfg_err", cfg_err, 0);
            check("abort_pixels", pix, abort_at);
            return;
        end
        check("fill_writes", fill_w, 2 * w);
        check("first_ren_pixel", first_ren, 2 * w + 1);
        check("pixels", pix, w * h);
        check("win_count", wins, (w - 2) * (h - 2));
        check("win_left", wq.size(), 0);
        check("done_latency", done_cyc, last_acc + 1);
        check("done_busy", busy, 1);
        check("occupancy", fifo_count, 2 * w);
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        check("post_done", done, 0);
        check("post_busy", busy, 0);
        check("post_ready", s_ready, 0);
    endtask

    initial begin
        cfg_vec_t vecs[7];
        vecs[0] = '{w: 9, h: 4, err: 1, bsy: 0, depth: 0};
        vecs[1] = '{w: 2, h: 4, err: 1, bsy: 0, depth: 0};
        vecs[2] = '{w: 8, h: 4, err: 0, bsy: 1, depth: 16};
        vecs[3] = '{w: 8, h: 2, err: 1, bsy: 0, depth: 0};
        vecs[4] = '{w: 3, h: 3, err: 0, bsy: 1, depth: 6};
        vecs[5] = '{w: 0, h: 5, err: 1, bsy: 0, depth: 0};
        vecs[6] = '{w: 5, h: 200, err: 0, bsy: 1, depth: 10};

        rst = 1'b1; start = 1'b0; img_w = '0; img_h = '0; s_valid = 1'b0; s_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_win", win_valid, 0);
        check("rst_depth", fifo_depth, 0);
        check("rst_clr_released", fifo_clr, 0);

        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            start = 1'b1; img_w = DIM_BIT'(vecs[i].w); img_h = DIM_BIT'(vecs[i].h);
            @(negedge clk);
            check("cfg_clr", fifo_clr, vecs[i].bsy);
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            check("cfg_err", cfg_err, vecs[i].err);
            check("cfg_busy", busy, vecs[i].bsy);
            check("cfg_ready", s_ready, vecs[i].bsy);
            check("cfg_depth", fifo_depth, vecs[i].depth);
            if (vecs[i].bsy) begin
                @(posedge clk); #1;
                start = 1'b1; img_w = 8'd2;
                @(negedge clk);
                check("busy_start_clr", fifo_clr, 0);
                @(posedge clk); #1;
                start = 1'b0;
                @(negedge clk);
                check("busy_start_err", cfg_err, 0);
                check("busy_start_depth", fifo_depth, vecs[i].depth);
                pulse_rst();
            end
        end

        run_frame(8, 4, 1'b0, 0, 0);
        run_frame(8, 4, 1'b1, 0, 0);
        run_frame(8, 4, 1'b0, 20, 0);
        run_frame(8, 4, 1'b0, 0, 0);
        run_frame(8, 4, 1'b0, 0, 22);
        run_frame(3, 5, 1'b1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/line_buf_ctrl.md
LINE_BUF_CTRL -- requirements
Module: line_buf_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, pixel width in bits.
REQ-002 Parameter ADDR_BIT, default 4, FIFO address bits; FIFO capacity 2**ADDR_BIT.
REQ-003 Parameter DIM_BIT, default 8, width of image row/column dimensions and counters.
REQ-004 Ports, clock and reset first:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame.
- img_w  in  DIM_BIT  image width in pixels, sampled on start.
- img_h  in  DIM_BIT  image height in rows, sampled on start.
- s_valid  in  1  input pixel valid.
- s_data  in  WIDTH  input pixel.
- s_ready  out  1  controller accepts pixel.
- fifo_clr  out  1  FIFO clear pulse, wired to the FIFO rst.
- fifo_wen  out  1  FIFO write enable.
- fifo_ren  out  1  FIFO read enable.
- fifo_in  out  WIDTH  FIFO write data.
- fifo_depth  out  ADDR_BIT+1  programmed delay length = 2*img_w.
- fifo_count  in  ADDR_BIT+1  FIFO occupancy.
- fifo_empty, fifo_full  in  1  FIFO flags, status only.
- win_valid  out  1  3x3 window taps valid.
- win_row, win_col  out  DIM_BIT  position of the window's bottom-right pixel.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after last pixel accepted.
- cfg_err  out  1  sticky; set on rejected start.

Function
REQ-005 States IDLE, FILL, STREAM, DONE; encoding shared via package.
REQ-006 IDLE: s_ready=0; on start with 3<=img_w, img_h>=3 and 2*img_w<=2**ADDR_BIT, latch img_w/img_h, pulse fifo_clr for one cycle, clear counters, go FILL; otherwise set cfg_err and stay IDLE.
REQ-007 Accept = s_valid && s_ready; s_ready=1 in FILL and STREAM only, combinational from state.
REQ-008 Each accept: fifo_wen=1, fifo_in=s_data, same cycle, combinational.
REQ-009 FILL: fifo_ren=0; transition to STREAM on the edge where an accept makes occupancy equal fifo_depth (fifo_count==fifo_depth-1 with accept).
REQ-010 STREAM: fifo_ren=accept; occupancy stays at fifo_depth; wen and ren asserted together.
REQ-011 Column counter increments per accept, wraps img_w-1 -> 0 and increments row counter.
REQ-012 Last pixel (row==img_h-1, col==img_w-1) accepted -> DONE; DONE lasts one cycle with done=1, then IDLE.
REQ-013 win_valid registered: asserted the cycle after an accept whose row>=2 and col>=2; win_row/win_col registered with it; 0 otherwise.
REQ-014 s_valid low: no state/counter change, no wen/ren.
REQ-015 start while busy ignored, cfg_err unchanged.
REQ-016 busy=1 in FILL, STREAM, DONE.
REQ-017 fifo_depth driven from latched img_w, stable for whole frame; 0 after reset.
REQ-018 cfg_err cleared only by rst or an accepted start.

Reset
REQ-019 rst has priority over all inputs, including start.
REQ-020 On rst: state IDLE, counters 0, s_ready, fifo_wen, fifo_ren, win_valid, done, busy, cfg_err = 0, fifo_clr=1 during rst cycle.
REQ-021 rst mid-frame aborts without done pulse; next start begins a clean frame.

Structure
REQ-022 Package line_buf_pkg holds the state type, state encodings and the 3x3 kernel-size constant (3).
REQ-023 One sub-module, rc_counter: row/column counter with wrap and last-pixel flag.

Verification
REQ-024 img_w=8, img_h=4, continuous s_valid, s_data=1,2,... -> 16 FILL writes, ren first on pixel 17, done one cycle after pixel 32 accepted.
REQ-025 Same frame -> win_valid exactly 12 cycles, first at (row2,col2) the cycle after pixel 19 accepted.
REQ-026 s_valid toggled every other cycle -> same counts as REQ-024/025, no wen/ren on idle cycles.
REQ-027 start with img_w=9 (ADDR_BIT=4) or img_w=2 -> cfg_err=1, busy=0; subsequent valid start clears cfg_err.
REQ-028 rst asserted at pixel 20 -> all outputs reset next cycle, no done; restart with img_w=8 repeats REQ-024.
REQ-029 start pulsed during STREAM -> ignored, frame completes unchanged.
